// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 4-digit multiplexed 7-segment scan controller
// Shadow/active double buffer so a frame is never torn; PWM brightness per slot.
module display_scan_ctrl #(
  parameter int SCAN_DIV = 1000
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Wr_Valid,
  output logic        o_Wr_Ready,
  input  logic [15:0] i_Wr_Data,
  input  logic [2:0]  i_Bright,
  input  logic        i_Blank_Lz,
  output logic [1:0]  o_Sel,
  output logic [3:0]  o_Anodos,
  output logic [6:0]  o_Segmentos,
  output logic        o_Frame
);

  localparam int PH_DIV = SCAN_DIV / 8;
  localparam int SW     = (PH_DIV > 1) ? $clog2(PH_DIV) : 1;
  localparam logic [SW-1:0] SUB_MAX = SW'(PH_DIV - 1);

  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_PENDING = 1'b1;

  // Prescaler is kept as {phase, sub}: prescaler = phase*PH_DIV + sub.
  logic [SW-1:0] sub_q, sub_d;
  logic [2:0]    phase_q, phase_d;
  logic [1:0]    idx_q, idx_d;
  logic [2:0]    level_q, level_d;
  logic [15:0]   active_q, active_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          state_q, state_d;
  logic          wr_ready_q, wr_ready_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    anodes_q, anodes_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_q, frame_d;

  logic       tc, boundary, lead_zero, lit;
  logic [3:0] nib;
  logic [6:0] dec;

  always_comb begin
    tc       = (phase_q == 3'd7) && (sub_q == SUB_MAX);
    boundary = tc && (idx_q == 2'd3);

    sub_d   = sub_q + 1'b1;
    phase_d = phase_q;
    if (sub_q == SUB_MAX) begin
      sub_d   = '0;
      phase_d = phase_q + 3'd1;
    end
    idx_d   = tc ? idx_q + 2'd1 : idx_q;
    level_d = (sub_q == '0 && phase_q == 3'd0) ? i_Bright : level_q;

    nib       = 4'h0;
    lead_zero = 1'b0;
    case (idx_q)
      2'd0: begin nib = active_q[15:12]; lead_zero = (active_q[15:12] == 4'h0); end
      2'd1: begin nib = active_q[11:8];  lead_zero = (active_q[15:8]  == 8'h0); end
      2'd2: begin nib = active_q[7:4];   lead_zero = (active_q[15:4]  == 12'h0); end
      default: begin nib = active_q[3:0]; lead_zero = 1'b0; end
    endcase

    case (nib)
      4'h0: dec = 7'h40;  4'h1: dec = 7'h79;  4'h2: dec = 7'h24;  4'h3: dec = 7'h30;
      4'h4: dec = 7'h19;  4'h5: dec = 7'h12;  4'h6: dec = 7'h02;  4'h7: dec = 7'h78;
      4'h8: dec = 7'h00;  4'h9: dec = 7'h10;  4'hA: dec = 7'h08;  4'hB: dec = 7'h03;
      4'hC: dec = 7'h46;  4'hD: dec = 7'h21;  4'hE: dec = 7'h06;  default: dec = 7'h0E;
    endcase

    // Phase 0 is always lit since level >= 0, giving the 1/8 minimum duty.
    lit = (phase_q <= level_q) && !(i_Blank_Lz && lead_zero);

    sel_d    = idx_q;
    anodes_d = lit ? (4'b1000 >> idx_q) : 4'b0000;
    seg_d    = lit ? dec : 7'h7F;
    frame_d  = boundary;

    state_d  = state_q;
    active_d = active_q;
    shadow_d = shadow_q;
    case (state_q)
      ST_IDLE: begin
        if (i_Wr_Valid) begin
          shadow_d = i_Wr_Data;
          state_d  = ST_PENDING;
        end
      end
      default: begin
        if (boundary) begin
          active_d = shadow_q;
          state_d  = ST_IDLE;
        end
      end
    endcase
    wr_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      sub_q      <= '0;
      phase_q    <= 3'd0;
      idx_q      <= 2'd0;
      level_q    <= 3'd7;
      active_q   <= 16'h0000;
      shadow_q   <= 16'h0000;
      state_q    <= ST_IDLE;
      wr_ready_q <= 1'b1;
      sel_q      <= 2'b00;
      anodes_q   <= 4'b0000;
      seg_q      <= 7'h7F;
      frame_q    <= 1'b0;
    end else begin
      sub_q      <= sub_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      level_q    <= level_d;
      active_q   <= active_d;
      shadow_q   <= shadow_d;
      state_q    <= state_d;
      wr_ready_q <= wr_ready_d;
      sel_q      <= sel_d;
      anodes_q   <= anodes_d;
      seg_q      <= seg_d;
      frame_q    <= frame_d;
    end
  end

  assign o_Wr_Ready  = wr_ready_q;
  assign o_Sel       = sel_q;
  assign o_Anodos    = anodes_q;
  assign o_Segmentos = seg_q;
  assign o_Frame     = frame_q;

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 1000, clocks per digit slot; SHALL be a multiple of 8 and at least 8.
REQ-002 SHALL provide port i_Clk  input  1  the single clock; all state on its rising edge.
REQ-003 SHALL provide port i_Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port i_Wr_Valid  input  1  write request for a new 4-digit value.
REQ-005 SHALL provide port o_Wr_Ready  output  1  controller can accept a write.
REQ-006 SHALL provide port i_Wr_Data  input  16  four hex nibbles; [15:12] = digit 0 (leftmost) ... [3:0] = digit 3.
REQ-007 SHALL provide port i_Bright  input  3  brightness level 0..7.
REQ-008 SHALL provide port i_Blank_Lz  input  1  enables leading-zero blanking.
REQ-009 SHALL provide port o_Sel  output  2  index of the digit being scanned.
REQ-010 SHALL provide port o_Anodos  output  4  one-hot anode enable, active-high.
REQ-011 SHALL provide port o_Segmentos  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-012 SHALL provide port o_Frame  output  1  one-cycle end-of-frame pulse.

Function
REQ-013 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; terminal count (TC) = SCAN_DIV-1.
REQ-014 Digit index SHALL advance 0->1->2->3->0 on each TC only.
REQ-015 o_Sel SHALL equal the registered digit index.
REQ-016 Anode map SHALL be: index 0 -> 4'b1000, 1 -> 4'b0100, 2 -> 4'b0010, 3 -> 4'b0001.
REQ-017 o_Sel, o_Anodos, o_Segmentos and o_Frame SHALL be registered: one cycle latency from internal state.
REQ-018 Brightness: level SHALL be sampled when the prescaler is 0. Phase = prescaler / (SCAN_DIV/8). The anode SHALL be enabled only while phase <= level. Level 7 = 100% on; level 0 = 1/8 on.
REQ-019 When the anode is disabled, o_Anodos SHALL be 4'b0000 and o_Segmentos SHALL be 7'h7F.
REQ-020 o_Segmentos SHALL be the active-low hex decode (0-F) of the active-register nibble for the current index. Examples: 0 -> 7'h40, 8 -> 7'h00, F -> 7'h0E.
REQ-021 Leading-zero blanking: with i_Blank_Lz=1, digit k<3 SHALL be blanked (per REQ-019) if nibbles 0..k are all zero. Digit 3 is never blanked.
REQ-022 Write FSM states: IDLE (o_Wr_Ready=1) and PENDING (o_Wr_Ready=0); o_Wr_Ready SHALL be a registered output.
REQ-023 IDLE -> PENDING on i_Wr_Valid & o_Wr_Ready; the shadow register SHALL capture i_Wr_Data in that cycle.
REQ-024 PENDING -> IDLE at frame boundary (TC while index=3): shadow SHALL copy into the active register, and o_Wr_Ready SHALL be 1 the following cycle.
REQ-025 The active register SHALL change only at a frame boundary, so the display is never torn mid-frame.
REQ-026 i_Wr_Valid while o_Wr_Ready=0 SHALL be ignored; the shadow SHALL be unchanged.
REQ-027 If a write is accepted in the same cycle as a frame boundary in IDLE, it SHALL be held until the next frame boundary.
REQ-028 o_Frame SHALL pulse for exactly one cycle, one cycle after each frame boundary.

Reset
REQ-029 While i_Reset=1, asynchronously: prescaler=0, index=0, active=16'h0000, shadow=16'h0000, FSM=IDLE, sampled level=7.
REQ-030 While i_Reset=1, outputs SHALL be: o_Wr_Ready=1, o_Sel=2'b00, o_Anodos=4'b0000, o_Segmentos=7'h7F, o_Frame=0.
REQ-031 Reset asserted mid-frame or in PENDING SHALL discard the pending write. Scanning SHALL restart at digit 0 on the first edge after release.

Verification (SCAN_DIV=8)
REQ-032 Reset release, no writes, i_Bright=7, i_Blank_Lz=0 -> o_Sel 0,1,2,3,0 every 8 cycles; o_Anodos 1000,0100,0010,0001; o_Segmentos=7'h40 throughout; o_Frame every 32 cycles.
REQ-033 Write 16'h12AF mid-frame -> o_Wr_Ready=0 next cycle; display stays 0000 until the frame boundary, then shows 1,2,A,F (7'h79,7'h24,7'h08,7'h0E); o_Wr_Ready=1 after the transfer.
REQ-034 Second write 16'h5555 while PENDING -> ignored; the display shows the first value after the boundary.
REQ-035 i_Bright=0 -> each anode is on 1 of 8 cycles per slot. i_Bright=3 -> each anode is on 4 of 8 cycles. A change mid-slot takes effect at the next slot start.
REQ-036 Active=16'h0047, i_Blank_Lz=1 -> digits 0,1 blanked (anode 0000, segments 7'h7F); digits 2,3 show 4,7. Active=16'h0000 -> only digit 3 is lit, showing 0.
REQ-037 Assert i_Reset while PENDING at index 2 -> all outputs go to reset values immediately; after release, the active value is 0000 and o_Wr_Ready=1.
